// File: rtl/udp_switch_pkg.sv
// Shared types for the UDP port router: header layout, payload widths,
// RX/TX state encodings and the endpoint index width helper.
package udp_switch_pkg;

    localparam int DATA_W = 8;
    localparam int KEEP_W = 1;

    typedef struct packed {
        logic [31:0] ip_addr;
        logic [15:0] source_port;
        logic [15:0] dest_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_hdr_t;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_HDR     = 2'd1,
        RX_PAYLOAD = 2'd2,
        RX_DROP    = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_HDR     = 2'd1,
        TX_PAYLOAD = 2'd2
    } tx_state_t;

    // Endpoint index width; a single endpoint still gets a 1-bit index.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udp_port_router_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer past the granted index when advance is pulsed.
module rr_arbiter
    import udp_switch_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic          found;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        int c;
        c         = 0;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            c = int'(ptr) + off;
            if (c >= N) c = c - N;
            if (req[c]) begin
                grant_idx = IW'(c);
                found     = 1'b1;
            end
        end
        if (found) grant[grant_idx] = 1'b1;
    end

    // Next search starts just after the index that was granted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/udp_port_router.sv
// Routes RX packets from the UDP stack to local endpoints by destination
// port, and merges endpoint TX packets round-robin toward the stack.
// Every channel: a transfer happens on a rising edge where valid && ready;
// a source holds valid and data stable until it transfers, and ready may
// depend combinationally on valid.
module udp_port_router
    import udp_switch_pkg::*;
#(
    parameter int          PORT_COUNT         = 2,
    parameter logic [15:0] PORTS [PORT_COUNT] = '{16'd1234, 16'd5678},
    parameter int          MISS_MODE          = 0,
    parameter int          DEFAULT_IDX        = 0,
    parameter int          CNT_WIDTH          = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    // per-endpoint TX sinks
    input  logic     [PORT_COUNT-1:0]             udp_tx_header_if_sink_valid,
    output logic     [PORT_COUNT-1:0]             udp_tx_header_if_sink_ready,
    input  udp_hdr_t [PORT_COUNT-1:0]             udp_tx_header_if_sink_hdr,
    input  logic     [PORT_COUNT-1:0][DATA_W-1:0] udp_tx_payload_if_sink_tdata,
    input  logic     [PORT_COUNT-1:0][KEEP_W-1:0] udp_tx_payload_if_sink_tkeep,
    input  logic     [PORT_COUNT-1:0]             udp_tx_payload_if_sink_tvalid,
    output logic     [PORT_COUNT-1:0]             udp_tx_payload_if_sink_tready,
    input  logic     [PORT_COUNT-1:0]             udp_tx_payload_if_sink_tlast,
    input  logic     [PORT_COUNT-1:0]             udp_tx_payload_if_sink_tuser,
    // per-endpoint RX sources
    output logic     [PORT_COUNT-1:0]             udp_rx_header_if_source_valid,
    input  logic     [PORT_COUNT-1:0]             udp_rx_header_if_source_ready,
    output udp_hdr_t [PORT_COUNT-1:0]             udp_rx_header_if_source_hdr,
    output logic     [PORT_COUNT-1:0][DATA_W-1:0] udp_rx_payload_if_source_tdata,
    output logic     [PORT_COUNT-1:0][KEEP_W-1:0] udp_rx_payload_if_source_tkeep,
    output logic     [PORT_COUNT-1:0]             udp_rx_payload_if_source_tvalid,
    input  logic     [PORT_COUNT-1:0]             udp_rx_payload_if_source_tready,
    output logic     [PORT_COUNT-1:0]             udp_rx_payload_if_source_tlast,
    output logic     [PORT_COUNT-1:0]             udp_rx_payload_if_source_tuser,
    // merged TX source toward the UDP stack
    output logic                                 udp_tx_header_if_source_valid,
    input  logic                                 udp_tx_header_if_source_ready,
    output udp_hdr_t                             udp_tx_header_if_source_hdr,
    output logic     [DATA_W-1:0]                udp_tx_payload_if_source_tdata,
    output logic     [KEEP_W-1:0]                udp_tx_payload_if_source_tkeep,
    output logic                                 udp_tx_payload_if_source_tvalid,
    input  logic                                 udp_tx_payload_if_source_tready,
    output logic                                 udp_tx_payload_if_source_tlast,
    output logic                                 udp_tx_payload_if_source_tuser,
    // RX sink from the UDP stack
    input  logic                                 udp_rx_header_if_sink_valid,
    output logic                                 udp_rx_header_if_sink_ready,
    input  udp_hdr_t                             udp_rx_header_if_sink_hdr,
    input  logic     [DATA_W-1:0]                udp_rx_payload_if_sink_tdata,
    input  logic     [KEEP_W-1:0]                udp_rx_payload_if_sink_tkeep,
    input  logic                                 udp_rx_payload_if_sink_tvalid,
    output logic                                 udp_rx_payload_if_sink_tready,
    input  logic                                 udp_rx_payload_if_sink_tlast,
    input  logic                                 udp_rx_payload_if_sink_tuser,
    // statistics and state visibility
    output logic     [CNT_WIDTH-1:0]             rx_drop_count,
    output logic     [CNT_WIDTH-1:0]             rx_fwd_count,
    output rx_state_t                            rx_state_dbg,
    output tx_state_t                            tx_state_dbg
);

    localparam int IW = idx_width(PORT_COUNT);

    rx_state_t       rx_state, rx_next;
    tx_state_t       tx_state, tx_next;
    udp_hdr_t        rx_hdr_q;
    logic [IW-1:0]   rx_sel, lookup_idx, tx_sel, arb_idx;
    logic [PORT_COUNT-1:0] arb_grant;
    logic            lookup_hit, ready_en, rx_fwd_inc, rx_drop_inc, arb_advance;

    assign rx_state_dbg = rx_state;
    assign tx_state_dbg = tx_state;

    // Lowest endpoint whose port matches the incoming destination wins.
    always_comb begin
        lookup_hit = 1'b0;
        lookup_idx = IW'(DEFAULT_IDX);
        for (int i = PORT_COUNT - 1; i >= 0; i--) begin
            if (udp_rx_header_if_sink_hdr.dest_port == PORTS[i]) begin
                lookup_hit = 1'b1;
                lookup_idx = IW'(i);
            end
        end
    end

    // RX state, captured header and target; ready_en keeps sinks closed until the first clock after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state <= RX_IDLE;
            rx_hdr_q <= '0;
            rx_sel   <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            rx_state <= rx_next;
            if (rx_state == RX_IDLE && udp_rx_header_if_sink_valid && ready_en) begin
                rx_hdr_q <= udp_rx_header_if_sink_hdr;
                rx_sel   <= lookup_idx;
            end
        end
    end

    // RX next state and steering; only the selected endpoint ever sees valid.
    always_comb begin
        rx_next                         = rx_state;
        rx_fwd_inc                      = 1'b0;
        rx_drop_inc                     = 1'b0;
        udp_rx_header_if_sink_ready     = 1'b0;
        udp_rx_payload_if_sink_tready   = 1'b0;
        udp_rx_header_if_source_valid   = '0;
        udp_rx_payload_if_source_tvalid = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            udp_rx_header_if_source_hdr[i]    = rx_hdr_q;
            udp_rx_payload_if_source_tdata[i] = udp_rx_payload_if_sink_tdata;
            udp_rx_payload_if_source_tkeep[i] = udp_rx_payload_if_sink_tkeep;
            udp_rx_payload_if_source_tlast[i] = udp_rx_payload_if_sink_tlast;
            udp_rx_payload_if_source_tuser[i] = udp_rx_payload_if_sink_tuser;
        end
        case (rx_state)
            RX_IDLE: begin
                udp_rx_header_if_sink_ready = ready_en;
                if (udp_rx_header_if_sink_valid && ready_en)
                    rx_next = (lookup_hit || MISS_MODE != 0) ? RX_HDR : RX_DROP;
            end
            RX_HDR: begin
                udp_rx_header_if_source_valid[rx_sel] = 1'b1;
                if (udp_rx_header_if_source_ready[rx_sel]) rx_next = RX_PAYLOAD;
            end
            RX_PAYLOAD: begin
                udp_rx_payload_if_source_tvalid[rx_sel] = udp_rx_payload_if_sink_tvalid;
                udp_rx_payload_if_sink_tready = udp_rx_payload_if_source_tready[rx_sel];
                if (udp_rx_payload_if_sink_tvalid && udp_rx_payload_if_source_tready[rx_sel]
                    && udp_rx_payload_if_sink_tlast) begin
                    rx_fwd_inc = 1'b1;
                    rx_next    = RX_IDLE;
                end
            end
            RX_DROP: begin
                udp_rx_payload_if_sink_tready = 1'b1;
                if (udp_rx_payload_if_sink_tvalid && udp_rx_payload_if_sink_tlast) begin
                    rx_drop_inc = 1'b1;
                    rx_next     = RX_IDLE;
                end
            end
            default: rx_next = RX_IDLE;
        endcase
    end

    // Saturating packet counters.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_fwd_count  <= '0;
            rx_drop_count <= '0;
        end else begin
            if (rx_fwd_inc && rx_fwd_count != '1) rx_fwd_count <= rx_fwd_count + 1'b1;
            if (rx_drop_inc && rx_drop_count != '1) rx_drop_count <= rx_drop_count + 1'b1;
        end
    end

    rr_arbiter #(.N(PORT_COUNT), .IW(IW)) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (udp_tx_header_if_sink_valid),
        .advance   (arb_advance),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    // TX state and the grant locked for the whole packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state <= TX_IDLE;
            tx_sel   <= '0;
        end else begin
            tx_state <= tx_next;
            if (arb_advance) tx_sel <= arb_idx;
        end
    end

    // TX next state and pass-through from the granted endpoint only.
    always_comb begin
        tx_next                         = tx_state;
        arb_advance                     = 1'b0;
        udp_tx_header_if_sink_ready     = '0;
        udp_tx_payload_if_sink_tready   = '0;
        udp_tx_header_if_source_valid   = 1'b0;
        udp_tx_payload_if_source_tvalid = 1'b0;
        udp_tx_header_if_source_hdr     = udp_tx_header_if_sink_hdr[tx_sel];
        udp_tx_payload_if_source_tdata  = udp_tx_payload_if_sink_tdata[tx_sel];
        udp_tx_payload_if_source_tkeep  = udp_tx_payload_if_sink_tkeep[tx_sel];
        udp_tx_payload_if_source_tlast  = udp_tx_payload_if_sink_tlast[tx_sel];
        udp_tx_payload_if_source_tuser  = udp_tx_payload_if_sink_tuser[tx_sel];
        case (tx_state)
            TX_IDLE: begin
                if (|arb_grant) begin
                    arb_advance = 1'b1;
                    tx_next     = TX_HDR;
                end
            end
            TX_HDR: begin
                udp_tx_header_if_source_valid       = udp_tx_header_if_sink_valid[tx_sel];
                udp_tx_header_if_sink_ready[tx_sel] = udp_tx_header_if_source_ready;
                if (udp_tx_header_if_sink_valid[tx_sel] && udp_tx_header_if_source_ready)
                    tx_next = TX_PAYLOAD;
            end
            TX_PAYLOAD: begin
                udp_tx_payload_if_source_tvalid       = udp_tx_payload_if_sink_tvalid[tx_sel];
                udp_tx_payload_if_sink_tready[tx_sel] = udp_tx_payload_if_source_tready;
                if (udp_tx_payload_if_sink_tvalid[tx_sel] && udp_tx_payload_if_source_tready
                    && udp_tx_payload_if_sink_tlast[tx_sel])
                    tx_next = TX_IDLE;
            end
            default: tx_next = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_udp_port_router.sv
// Directed bench for udp_port_router: RX forward/drop/stall/zero-length,
// miss-to-default, TX round-robin, mid-packet reset and counter saturation.
module tb_udp_port_router;
    import udp_switch_pkg::*;

    int total = 0;
    int bad   = 0;
    int exp_fwd  = 0;
    int exp_drop = 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    // DUT A signals (drop on miss, 3-bit counters)
    logic [1:0] txh_valid, txh_ready;
    udp_hdr_t [1:0] txh;
    logic [1:0][7:0] txp_tdata;
    logic [1:0][0:0] txp_tkeep;
    logic [1:0] txp_tvalid, txp_tready, txp_tlast, txp_tuser;
    logic [1:0] eph_valid, eph_ready;
    udp_hdr_t [1:0] eph;
    logic [1:0][7:0] epp_tdata;
    logic [1:0][0:0] epp_tkeep;
    logic [1:0] epp_tvalid, epp_tready, epp_tlast, epp_tuser;
    logic outh_valid, outh_ready;
    udp_hdr_t outh;
    logic [7:0] outp_tdata;
    logic [0:0] outp_tkeep;
    logic outp_tvalid, outp_tready, outp_tlast, outp_tuser;
    logic rxh_valid, rxh_ready;
    udp_hdr_t rxh;
    logic [7:0] rxp_tdata;
    logic [0:0] rxp_tkeep;
    logic rxp_tvalid, rxp_tready, rxp_tlast, rxp_tuser;
    logic [2:0] drop_cnt, fwd_cnt;
    rx_state_t rx_dbg;
    tx_state_t tx_dbg;

    // DUT B signals (forward misses to endpoint 0)
    logic [1:0] b_txh_ready, b_txp_tready;
    logic b_outh_valid, b_outp_tvalid, b_outp_tlast, b_outp_tuser;
    udp_hdr_t b_outh;
    logic [7:0] b_outp_tdata;
    logic [0:0] b_outp_tkeep;
    logic [1:0] b_eph_valid, b_eph_ready;
    udp_hdr_t [1:0] b_eph;
    logic [1:0][7:0] b_epp_tdata;
    logic [1:0][0:0] b_epp_tkeep;
    logic [1:0] b_epp_tvalid, b_epp_tready, b_epp_tlast, b_epp_tuser;
    logic b_rxh_valid, b_rxh_ready;
    udp_hdr_t b_rxh;
    logic [7:0] b_rxp_tdata;
    logic b_rxp_tvalid, b_rxp_tready, b_rxp_tlast;
    logic [2:0] b_drop_cnt, b_fwd_cnt;
    rx_state_t b_rx_dbg;
    tx_state_t b_tx_dbg;

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, want summary before it");
        $fatal(1, "watchdog");
    end

    udp_port_router #(.CNT_WIDTH(3)) dut_a (
        .clk(clk), .reset_n(reset_n),
        .udp_tx_header_if_sink_valid(txh_valid), .udp_tx_header_if_sink_ready(txh_ready),
        .udp_tx_header_if_sink_hdr(txh),
        .udp_tx_payload_if_sink_tdata(txp_tdata), .udp_tx_payload_if_sink_tkeep(txp_tkeep),
        .udp_tx_payload_if_sink_tvalid(txp_tvalid), .udp_tx_payload_if_sink_tready(txp_tready),
        .udp_tx_payload_if_sink_tlast(txp_tlast), .udp_tx_payload_if_sink_tuser(txp_tuser),
        .udp_rx_header_if_source_valid(eph_valid), .udp_rx_header_if_source_ready(eph_ready),
        .udp_rx_header_if_source_hdr(eph),
        .udp_rx_payload_if_source_tdata(epp_tdata), .udp_rx_payload_if_source_tkeep(epp_tkeep),
        .udp_rx_payload_if_source_tvalid(epp_tvalid), .udp_rx_payload_if_source_tready(epp_tready),
        .udp_rx_payload_if_source_tlast(epp_tlast), .udp_rx_payload_if_source_tuser(epp_tuser),
        .udp_tx_header_if_source_valid(outh_valid), .udp_tx_header_if_source_ready(outh_ready),
        .udp_tx_header_if_source_hdr(outh),
        .udp_tx_payload_if_source_tdata(outp_tdata), .udp_tx_payload_if_source_tkeep(outp_tkeep),
        .udp_tx_payload_if_source_tvalid(outp_tvalid), .udp_tx_payload_if_source_tready(outp_tready),
        .udp_tx_payload_if_source_tlast(outp_tlast), .udp_tx_payload_if_source_tuser(outp_tuser),
        .udp_rx_header_if_sink_valid(rxh_valid), .udp_rx_header_if_sink_ready(rxh_ready),
        .udp_rx_header_if_sink_hdr(rxh),
        .udp_rx_payload_if_sink_tdata(rxp_tdata), .udp_rx_payload_if_sink_tkeep(rxp_tkeep),
        .udp_rx_payload_if_sink_tvalid(rxp_tvalid), .udp_rx_payload_if_sink_tready(rxp_tready),
        .udp_rx_payload_if_sink_tlast(rxp_tlast), .udp_rx_payload_if_sink_tuser(rxp_tuser),
        .rx_drop_count(drop_cnt), .rx_fwd_count(fwd_cnt),
        .rx_state_dbg(rx_dbg), .tx_state_dbg(tx_dbg)
    );

    udp_port_router #(.MISS_MODE(1), .DEFAULT_IDX(0), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .reset_n(reset_n),
        .udp_tx_header_if_sink_valid(2'b00), .udp_tx_header_if_sink_ready(b_txh_ready),
        .udp_tx_header_if_sink_hdr('0),
        .udp_tx_payload_if_sink_tdata('0), .udp_tx_payload_if_sink_tkeep('0),
        .udp_tx_payload_if_sink_tvalid(2'b00), .udp_tx_payload_if_sink_tready(b_txp_tready),
        .udp_tx_payload_if_sink_tlast(2'b00), .udp_tx_payload_if_sink_tuser(2'b00),
        .udp_rx_header_if_source_valid(b_eph_valid), .udp_rx_header_if_source_ready(b_eph_ready),
        .udp_rx_header_if_source_hdr(b_eph),
        .udp_rx_payload_if_source_tdata(b_epp_tdata), .udp_rx_payload_if_source_tkeep(b_epp_tkeep),
        .udp_rx_payload_if_source_tvalid(b_epp_tvalid), .udp_rx_payload_if_source_tready(b_epp_tready),
        .udp_rx_payload_if_source_tlast(b_epp_tlast), .udp_rx_payload_if_source_tuser(b_epp_tuser),
        .udp_tx_header_if_source_valid(b_outh_valid), .udp_tx_header_if_source_ready(1'b1),
        .udp_tx_header_if_source_hdr(b_outh),
        .udp_tx_payload_if_source_tdata(b_outp_tdata), .udp_tx_payload_if_source_tkeep(b_outp_tkeep),
        .udp_tx_payload_if_source_tvalid(b_outp_tvalid), .udp_tx_payload_if_source_tready(1'b1),
        .udp_tx_payload_if_source_tlast(b_outp_tlast), .udp_tx_payload_if_source_tuser(b_outp_tuser),
        .udp_rx_header_if_sink_valid(b_rxh_valid), .udp_rx_header_if_sink_ready(b_rxh_ready),
        .udp_rx_header_if_sink_hdr(b_rxh),
        .udp_rx_payload_if_sink_tdata(b_rxp_tdata), .udp_rx_payload_if_sink_tkeep(1'b1),
        .udp_rx_payload_if_sink_tvalid(b_rxp_tvalid), .udp_rx_payload_if_sink_tready(b_rxp_tready),
        .udp_rx_payload_if_sink_tlast(b_rxp_tlast), .udp_rx_payload_if_sink_tuser(1'b0),
        .rx_drop_count(b_drop_cnt), .rx_fwd_count(b_fwd_cnt),
        .rx_state_dbg(b_rx_dbg), .tx_state_dbg(b_tx_dbg)
    );

    function automatic udp_hdr_t make_hdr(input logic [15:0] dest, input int nbeats);
        udp_hdr_t h;
        h.ip_addr     = {16'hC0A8, dest};
        h.source_port = ~dest;
        h.dest_port   = dest;
        h.length      = 16'(8 + nbeats);
        h.checksum    = dest ^ 16'h5A5A;
        return h;
    endfunction

    // driver: one RX packet on DUT A; exp_ep < 0 means it must be dropped
    task automatic rx_packet(input logic [15:0] dest, input int nbeats, input int exp_ep,
                             input int stall_beat, input int stall_len);
        udp_hdr_t h;
        logic [1:0] exp_vld;
        logic [7:0] d;
        int waits;
        h = make_hdr(dest, nbeats);
        exp_vld = (exp_ep >= 0) ? 2'(1 << exp_ep) : 2'b00;
        @(negedge clk);
        rxh = h;
        rxh_valid = 1'b1;
        waits = 0;
        #1;
        while (!rxh_ready && waits < 50) begin
            @(negedge clk);
            #1;
            waits++;
        end
        total++;
        if (rxh_ready !== 1'b1) begin
            bad++;
            $display("FAIL rx_hdr_accept dest=%0d: ready=%b want 1", dest, rxh_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rxh_valid = 1'b0;
        #1;
        total++;
        if (eph_valid !== exp_vld) begin
            bad++;
            $display("FAIL rx_hdr_valid dest=%0d: got %b want %b", dest, eph_valid, exp_vld);
        end
        if (exp_ep >= 0) begin
            total++;
            if (eph[exp_ep] !== h) begin
                bad++;
                $display("FAIL rx_hdr_fields dest=%0d: got %h want %h", dest, eph[exp_ep], h);
            end
        end
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clk);
            d = dest[7:0] + 8'(b * 3);
            rxp_tdata  = d;
            rxp_tkeep  = 1'b1;
            rxp_tuser  = b[0];
            rxp_tlast  = (b == nbeats - 1);
            rxp_tvalid = 1'b1;
            if (b == stall_beat && exp_ep >= 0) begin
                epp_tready[exp_ep] = 1'b0;
                rxh = make_hdr(16'd1234, 2);
                rxh_valid = 1'b1;
                for (int s = 0; s < stall_len; s++) begin
                    #1;
                    total++;
                    if (rxp_tready !== 1'b0 || rxh_ready !== 1'b0 || epp_tvalid !== exp_vld) begin
                        bad++;
                        $display("FAIL rx_stall cycle %0d: tready=%b hdr_ready=%b tvalid=%b want 0 0 %b",
                                 s, rxp_tready, rxh_ready, epp_tvalid, exp_vld);
                    end
                    @(negedge clk);
                end
                epp_tready[exp_ep] = 1'b1;
                rxh_valid = 1'b0;
            end
            #1;
            total++;
            if (rxp_tready !== 1'b1 || epp_tvalid !== exp_vld || eph_valid !== 2'b00) begin
                bad++;
                $display("FAIL rx_beat %0d dest=%0d: tready=%b tvalid=%b hvalid=%b want 1 %b 00",
                         b, dest, rxp_tready, epp_tvalid, eph_valid, exp_vld);
            end
            if (exp_ep >= 0) begin
                total++;
                if (epp_tdata[exp_ep] !== d || epp_tlast[exp_ep] !== (b == nbeats - 1)
                    || epp_tuser[exp_ep] !== b[0]) begin
                    bad++;
                    $display("FAIL rx_data beat %0d: got %h last=%b want %h last=%b",
                             b, epp_tdata[exp_ep], epp_tlast[exp_ep], d, (b == nbeats - 1));
                end
            end
            @(posedge clk);
        end
        @(negedge clk);
        rxp_tvalid = 1'b0;
        rxp_tlast  = 1'b0;
        if (exp_ep >= 0) exp_fwd  = (exp_fwd  == 7) ? 7 : exp_fwd + 1;
        else             exp_drop = (exp_drop == 7) ? 7 : exp_drop + 1;
        #1;
        total++;
        if (fwd_cnt !== 3'(exp_fwd) || drop_cnt !== 3'(exp_drop) || rx_dbg !== RX_IDLE) begin
            bad++;
            $display("FAIL rx_counts dest=%0d: fwd=%0d drop=%0d state=%0d want %0d %0d 0",
                     dest, fwd_cnt, drop_cnt, rx_dbg, exp_fwd, exp_drop);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        txh_valid = '0; txh = '0; txp_tdata = '0; txp_tkeep = '0;
        txp_tvalid = '0; txp_tlast = '0; txp_tuser = '0;
        eph_ready = 2'b11; epp_tready = 2'b11;
        outh_ready = 1'b1; outp_tready = 1'b1;
        rxh_valid = 1'b0; rxh = '0; rxp_tdata = '0; rxp_tkeep = '0;
        rxp_tvalid = 1'b0; rxp_tlast = 1'b0; rxp_tuser = 1'b0;
        b_eph_ready = 2'b11; b_epp_tready = 2'b11;
        b_rxh_valid = 1'b0; b_rxh = '0; b_rxp_tdata = '0; b_rxp_tvalid = 1'b0; b_rxp_tlast = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (rxh_ready !== 1'b0 || rxp_tready !== 1'b0 || txh_ready !== 2'b00 || txp_tready !== 2'b00) begin
            bad++;
            $display("FAIL reset_readies: rx %b%b tx %b%b want all 0", rxh_ready, rxp_tready, txh_ready, txp_tready);
        end
        total++;
        if (eph_valid !== 2'b00 || epp_tvalid !== 2'b00 || outh_valid !== 1'b0 || outp_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL reset_valids: %b %b %b %b want 0", eph_valid, epp_tvalid, outh_valid, outp_tvalid);
        end
        total++;
        if (drop_cnt !== 3'd0 || fwd_cnt !== 3'd0 || rx_dbg !== RX_IDLE || tx_dbg !== TX_IDLE) begin
            bad++;
            $display("FAIL reset_state: drop=%0d fwd=%0d rx=%0d tx=%0d want 0 0 0 0", drop_cnt, fwd_cnt, rx_dbg, tx_dbg);
        end
        reset_n = 1'b1;
        #1;
        total++;
        if (rxh_ready !== 1'b0) begin
            bad++;
            $display("FAIL release_ready_before_clock: got %b want 0", rxh_ready);
        end
        @(negedge clk);
        total++;
        if (rxh_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready_after_clock: got %b want 1", rxh_ready);
        end
        exp_fwd = 0;
        exp_drop = 0;
    endtask

    task automatic test_rx_forward();
        rx_packet(16'd5678, 4, 1, -1, 0);
    endtask

    task automatic test_rx_drop();
        rx_packet(16'd9999, 3, -1, -1, 0);
    endtask

    task automatic test_rx_stall();
        rx_packet(16'd5678, 6, 1, 2, 10);
    endtask

    task automatic test_zero_length();
        rx_packet(16'd1234, 1, 0, -1, 0);
        rx_packet(16'd4321, 1, -1, -1, 0);
    endtask

    task automatic test_miss_default();
        udp_hdr_t h;
        logic [7:0] d;
        h = make_hdr(16'd9999, 3);
        @(negedge clk);
        b_rxh = h;
        b_rxh_valid = 1'b1;
        #1;
        total++;
        if (b_rxh_ready !== 1'b1) begin
            bad++;
            $display("FAIL miss_hdr_ready: got %b want 1", b_rxh_ready);
        end
        @(posedge clk);
        @(negedge clk);
        b_rxh_valid = 1'b0;
        #1;
        total++;
        if (b_eph_valid !== 2'b01 || b_eph[0] !== h) begin
            bad++;
            $display("FAIL miss_hdr: valid=%b hdr=%h want 01 %h", b_eph_valid, b_eph[0], h);
        end
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            d = 8'h40 + 8'(b);
            b_rxp_tdata = d;
            b_rxp_tlast = (b == 2);
            b_rxp_tvalid = 1'b1;
            #1;
            total++;
            if (b_epp_tvalid !== 2'b01 || b_epp_tdata[0] !== d || b_epp_tlast[0] !== (b == 2)) begin
                bad++;
                $display("FAIL miss_beat %0d: valid=%b data=%h want 01 %h", b, b_epp_tvalid, b_epp_tdata[0], d);
            end
            @(posedge clk);
        end
        @(negedge clk);
        b_rxp_tvalid = 1'b0;
        b_rxp_tlast = 1'b0;
        #1;
        total++;
        if (b_fwd_cnt !== 3'd1 || b_drop_cnt !== 3'd0) begin
            bad++;
            $display("FAIL miss_counts: fwd=%0d drop=%0d want 1 0", b_fwd_cnt, b_drop_cnt);
        end
    endtask

    task automatic test_tx_round_robin();
        logic [15:0] exp_h[$];
        logic [7:0]  exp_d[$];
        int pkt[2];
        int ph[2];
        logic [1:0] hs_h, hs_p;
        int cyc;
        for (int p = 0; p < 2; p++)
            for (int ep = 0; ep < 2; ep++) begin
                exp_h.push_back(16'(ep * 16 + p));
                exp_d.push_back(8'(ep * 16 + p * 4));
                exp_d.push_back(8'(ep * 16 + p * 4 + 1));
            end
        pkt = '{0, 0};
        ph  = '{0, 0};
        cyc = 0;
        while (exp_d.size() > 0 && cyc < 200) begin
            @(negedge clk);
            for (int ep = 0; ep < 2; ep++) begin
                if (pkt[ep] < 2) begin
                    txh_valid[ep] = (ph[ep] == 0);
                    txh[ep] = make_hdr(16'd3000, 2);
                    txh[ep].source_port = 16'(ep * 16 + pkt[ep]);
                    txp_tvalid[ep] = (ph[ep] != 0);
                    txp_tdata[ep] = 8'(ep * 16 + pkt[ep] * 4 + ph[ep] - 1);
                    txp_tlast[ep] = (ph[ep] == 2);
                    txp_tkeep[ep] = 1'b1;
                end else begin
                    txh_valid[ep] = 1'b0;
                    txp_tvalid[ep] = 1'b0;
                end
            end
            #1;
            hs_h = txh_valid & txh_ready;
            hs_p = txp_tvalid & txp_tready;
            total++;
            if ($countones({txh_ready, txp_tready}) > 1) begin
                bad++;
                $display("FAIL tx_ready_onehot cycle %0d: hdr=%b pay=%b want at most one", cyc, txh_ready, txp_tready);
            end
            if (outh_valid && outh_ready) begin
                total++;
                if (exp_h.size() == 0 || outh.source_port !== exp_h[0]) begin
                    bad++;
                    $display("FAIL tx_hdr_order: got %h want %h", outh.source_port,
                             (exp_h.size() > 0) ? exp_h[0] : 16'hFFFF);
                end
                if (exp_h.size() > 0) void'(exp_h.pop_front());
            end
            if (outp_tvalid && outp_tready) begin
                total++;
                if (exp_d.size() == 0 || outp_tdata !== exp_d[0] || outp_tlast !== exp_d[0][0]) begin
                    bad++;
                    $display("FAIL tx_data_order: got %h last=%b want %h", outp_tdata, outp_tlast,
                             (exp_d.size() > 0) ? exp_d[0] : 8'hFF);
                end
                if (exp_d.size() > 0) void'(exp_d.pop_front());
            end
            @(posedge clk);
            for (int ep = 0; ep < 2; ep++) begin
                if (hs_h[ep]) ph[ep] = 1;
                else if (hs_p[ep]) begin
                    if (ph[ep] == 2) begin
                        ph[ep] = 0;
                        pkt[ep]++;
                    end else ph[ep]++;
                end
            end
            cyc++;
        end
        @(negedge clk);
        txh_valid = '0;
        txp_tvalid = '0;
        #1;
        total++;
        if (exp_h.size() != 0 || exp_d.size() != 0 || tx_dbg !== TX_IDLE) begin
            bad++;
            $display("FAIL tx_complete: left hdr=%0d data=%0d state=%0d want 0 0 0", exp_h.size(), exp_d.size(), tx_dbg);
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        rxh = make_hdr(16'd1234, 5);
        rxh_valid = 1'b1;
        #1;
        total++;
        if (rxh_ready !== 1'b1) begin
            bad++;
            $display("FAIL midrst_hdr_ready: got %b want 1", rxh_ready);
        end
        @(posedge clk);
        @(negedge clk);
        rxh_valid = 1'b0;
        @(negedge clk);
        rxp_tdata = 8'h11; rxp_tvalid = 1'b1; rxp_tlast = 1'b0;
        @(negedge clk);
        rxp_tdata = 8'h22;
        #1;
        total++;
        if (epp_tvalid !== 2'b01) begin
            bad++;
            $display("FAIL midrst_beat2_valid: got %b want 01", epp_tvalid);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (eph_valid !== 2'b00 || epp_tvalid !== 2'b00 || rxp_tready !== 1'b0 || rxh_ready !== 1'b0) begin
            bad++;
            $display("FAIL midrst_outputs: hv=%b pv=%b tready=%b hready=%b want 00 00 0 0",
                     eph_valid, epp_tvalid, rxp_tready, rxh_ready);
        end
        total++;
        if (fwd_cnt !== 3'd0 || drop_cnt !== 3'd0 || rx_dbg !== RX_IDLE) begin
            bad++;
            $display("FAIL midrst_counts: fwd=%0d drop=%0d state=%0d want 0 0 0", fwd_cnt, drop_cnt, rx_dbg);
        end
        rxp_tvalid = 1'b0;
        exp_fwd = 0;
        exp_drop = 0;
        @(negedge clk);
        reset_n = 1'b1;
        rx_packet(16'd1234, 3, 0, -1, 0);
    endtask

    task automatic test_drop_saturate();
        for (int k = 0; k < 8; k++) rx_packet(16'd7000 + 16'(k), 1, -1, -1, 0);
        total++;
        if (drop_cnt !== 3'b111) begin
            bad++;
            $display("FAIL drop_saturate: got %0d want 7", drop_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_rx_forward();
        test_rx_drop();
        test_rx_stall();
        test_zero_length();
        test_miss_default();
        test_tx_round_robin();
        test_mid_reset();
        test_drop_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
